// File: rtl/ro_sensor_pkg.sv
// Shared types and constants for the RO frequency sensor measurement path.
package ro_sensor_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 32;
   localparam int SETTLE_W   = 16;

   // Controller states. RD_ISSUE/RD_LATCH/RD_HOLD are the per-word readout
   // substates owned by the read streamer.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLEAR    = 3'd1,
      SETTLE   = 3'd2,
      MEASURE  = 3'd3,
      RD_ISSUE = 3'd4,
      RD_LATCH = 3'd5,
      RD_HOLD  = 3'd6,
      DONE     = 3'd7
   } ro_ctrl_state_t;

endpackage

// File: rtl/ro_rd_streamer.sv
// Readout engine: walks RAM port B from address 0 to num-1 and presents each
// word on a valid/ready port. Three cycles minimum per word (issue, latch, hold).
//
// Handshake: rd_valid rises with rd_data already stable and both stay unchanged
// until a cycle with rd_valid & rd_ready; that cycle transfers the word and
// rd_valid is low on the following cycle. rd_valid never depends on rd_ready.
module ro_rd_streamer
   import ro_sensor_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                 clk_origin,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 go,
   input  logic [ADDR_W:0]      num,
   input  logic [DATA_W-1:0]    ram_rdata,
   input  logic                 rd_ready,
   output logic                 ram_re,
   output logic [ADDR_W-1:0]    ram_raddr,
   output logic                 rd_valid,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 fin,
   output ro_ctrl_state_t       rd_state
);

   logic [ADDR_W:0] last_idx;

   assign last_idx = num - 1'b1;

   // Per-word read sequence; clr drops every enable at once and returns to idle.
   always_ff @(posedge clk_origin or negedge rst) begin
      if (!rst) begin
         rd_state  <= IDLE;
         ram_re    <= 1'b0;
         ram_raddr <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         fin       <= 1'b0;
      end else if (clr) begin
         rd_state <= IDLE;
         ram_re   <= 1'b0;
         rd_valid <= 1'b0;
         fin      <= 1'b0;
      end else begin
         fin    <= 1'b0;
         ram_re <= 1'b0;
         case (rd_state)
            IDLE: begin
               if (go) begin
                  rd_state  <= RD_ISSUE;
                  ram_re    <= 1'b1;
                  ram_raddr <= '0;
               end
            end
            RD_ISSUE: rd_state <= RD_LATCH;
            RD_LATCH: begin
               rd_data  <= ram_rdata;
               rd_valid <= 1'b1;
               rd_state <= RD_HOLD;
            end
            RD_HOLD: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if ({1'b0, ram_raddr} == last_idx) begin
                     fin      <= 1'b1;
                     rd_state <= IDLE;
                  end else begin
                     ram_raddr <= ram_raddr + 1'b1;
                     ram_re    <= 1'b1;
                     rd_state  <= RD_ISSUE;
                  end
               end
            end
            default: rd_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ro_meas_ctrl.sv
// Measurement sequencer: optional RAM clear, settle window, capture of N
// samples into consecutive addresses, then readout through ro_rd_streamer.
module ro_meas_ctrl
   import ro_sensor_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter bit CLEAR_EN = 1'b1
) (
   input  logic                 clk_origin,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W:0]      cfg_num_samples,
   input  logic [SETTLE_W-1:0]  cfg_settle_cycles,
   input  logic                 sample_valid,
   input  logic [DATA_W-1:0]    sample_data,
   output logic                 inst_valid,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_waddr,
   output logic [DATA_W-1:0]    ram_wdata,
   output logic                 ram_re,
   output logic [ADDR_W-1:0]    ram_raddr,
   input  logic [DATA_W-1:0]    ram_rdata,
   output logic                 rd_valid,
   output logic [DATA_W-1:0]    rd_data,
   input  logic                 rd_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 cfg_err,
   output logic [ADDR_W:0]      sample_count,
   output ro_ctrl_state_t       state_dbg
);

   localparam logic [ADDR_W:0]   DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

   ro_ctrl_state_t        state;
   ro_ctrl_state_t        rd_state;
   logic [ADDR_W:0]       num_lat;
   logic [SETTLE_W-1:0]   settle_cnt;
   logic [ADDR_W-1:0]     wr_ptr;
   logic                  rd_go;
   logic                  rd_fin;
   logic                  cfg_bad;

   assign cfg_bad = (cfg_num_samples == '0) || (cfg_num_samples > DEPTH_V);

   // While reading out, the streamer's substate is the more useful view.
   assign state_dbg = (state == RD_ISSUE && rd_state != IDLE) ? rd_state : state;

   // Campaign FSM; abort outside IDLE overrides everything else.
   always_ff @(posedge clk_origin or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         num_lat      <= '0;
         settle_cnt   <= '0;
         wr_ptr       <= '0;
         rd_go        <= 1'b0;
         inst_valid   <= 1'b0;
         ram_we       <= 1'b0;
         ram_waddr    <= '0;
         ram_wdata    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         cfg_err      <= 1'b0;
         sample_count <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         cfg_err <= 1'b0;
         rd_go   <= 1'b0;
         ram_we  <= 1'b0;
         if (abort && state != IDLE) begin
            state      <= IDLE;
            busy       <= 1'b0;
            aborted    <= 1'b1;
            inst_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     if (cfg_bad) begin
                        cfg_err <= 1'b1;
                     end else begin
                        num_lat      <= cfg_num_samples;
                        settle_cnt   <= cfg_settle_cycles;
                        sample_count <= '0;
                        wr_ptr       <= '0;
                        busy         <= 1'b1;
                        if (CLEAR_EN) begin
                           state     <= CLEAR;
                           ram_we    <= 1'b1;
                           ram_waddr <= '0;
                           ram_wdata <= '0;
                        end else begin
                           inst_valid <= 1'b1;
                           state      <= (cfg_settle_cycles == '0) ? MEASURE : SETTLE;
                        end
                     end
                  end
               end
               CLEAR: begin
                  if (ram_waddr == LAST_ADR) begin
                     inst_valid <= 1'b1;
                     state      <= (settle_cnt == '0) ? MEASURE : SETTLE;
                  end else begin
                     ram_we    <= 1'b1;
                     ram_waddr <= ram_waddr + 1'b1;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == SETTLE_W'(1)) begin
                     state <= MEASURE;
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               MEASURE: begin
                  if (sample_valid) begin
                     ram_we       <= 1'b1;
                     ram_waddr    <= wr_ptr;
                     ram_wdata    <= sample_data;
                     wr_ptr       <= wr_ptr + 1'b1;
                     sample_count <= sample_count + 1'b1;
                     if ((sample_count + 1'b1) == num_lat) begin
                        inst_valid <= 1'b0;
                        rd_go      <= 1'b1;
                        state      <= RD_ISSUE;
                     end
                  end
               end
               RD_ISSUE: begin
                  if (rd_fin) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   ro_rd_streamer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rd_streamer (
      .clk_origin (clk_origin),
      .rst        (rst),
      .clr        (abort),
      .go         (rd_go),
      .num        (num_lat),
      .ram_rdata  (ram_rdata),
      .rd_ready   (rd_ready),
      .ram_re     (ram_re),
      .ram_raddr  (ram_raddr),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .fin        (rd_fin),
      .rd_state   (rd_state)
   );

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Bench for ro_meas_ctrl with ADDR_W=4 and a behavioural 1-cycle-latency RAM.
module tb_ro_meas_ctrl;
   import ro_sensor_pkg::*;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic            clk_origin;
   logic            rst;
   logic            start;
   logic            abort;
   logic [AW:0]     cfg_num_samples;
   logic [15:0]     cfg_settle_cycles;
   logic            sample_valid;
   logic [DW-1:0]   sample_data;
   logic            inst_valid;
   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [DW-1:0]   ram_wdata;
   logic            ram_re;
   logic [AW-1:0]   ram_raddr;
   logic [DW-1:0]   ram_rdata;
   logic            rd_valid;
   logic [DW-1:0]   rd_data;
   logic            rd_ready;
   logic            busy;
   logic            done;
   logic            aborted;
   logic            cfg_err;
   logic [AW:0]     sample_count;
   ro_ctrl_state_t  state_dbg;

   int vectors;
   int miscompares;

   // Scoreboard: expected port-A sample writes {last, addr, data} and readout words.
   logic [63:0]   exp_wq[$];
   logic [DW-1:0] exp_q[$];

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] clr_addr_exp;
   int            clr_writes;
   int            wr_total;
   int            done_cnt;
   int            abort_cnt;
   int            wr_idx;
   int            cur_n;

   ro_meas_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .CLEAR_EN (1'b1)
   ) dut (
      .clk_origin        (clk_origin),
      .rst               (rst),
      .start             (start),
      .abort             (abort),
      .cfg_num_samples   (cfg_num_samples),
      .cfg_settle_cycles (cfg_settle_cycles),
      .sample_valid      (sample_valid),
      .sample_data       (sample_data),
      .inst_valid        (inst_valid),
      .ram_we            (ram_we),
      .ram_waddr         (ram_waddr),
      .ram_wdata         (ram_wdata),
      .ram_re            (ram_re),
      .ram_raddr         (ram_raddr),
      .ram_rdata         (ram_rdata),
      .rd_valid          (rd_valid),
      .rd_data           (rd_data),
      .rd_ready          (rd_ready),
      .busy              (busy),
      .done              (done),
      .aborted           (aborted),
      .cfg_err           (cfg_err),
      .sample_count      (sample_count),
      .state_dbg         (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk_origin = 1'b0;
   always #5 clk_origin = ~clk_origin;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Dual-port RAM model with 1-cycle read latency.
   always @(posedge clk_origin) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Output monitor, sampled mid-cycle.
   always @(negedge clk_origin) begin
      if (rst) begin
         if (done) done_cnt++;
         if (aborted) abort_cnt++;
         if (ram_we) begin
            wr_total++;
            if (state_dbg == CLEAR) begin
               check("clr_addr", 64'(ram_waddr), 64'(clr_addr_exp));
               check("clr_data", 64'(ram_wdata), 64'd0);
               clr_addr_exp++;
               clr_writes++;
            end else if (exp_wq.size() == 0) begin
               check("unexp_write", 64'(ram_waddr) | 64'h100, 64'd0);
            end else begin
               logic [63:0] e;
               e = exp_wq.pop_front();
               check("wr_addr", 64'(ram_waddr), 64'(e[39:32]));
               check("wr_data", 64'(ram_wdata), 64'(e[31:0]));
               check("inst_valid_at_wr", 64'(inst_valid), 64'(!e[40]));
            end
         end
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("unexp_word", 64'(rd_data) | 64'h1_0000_0000, 64'd0);
            else check("rd_word", 64'(rd_data), 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_origin);
      #1;
   endtask

   task automatic do_start(input int n, input int settle);
      cfg_num_samples   = (AW+1)'(n);
      cfg_settle_cycles = 16'(settle);
      cur_n  = n;
      wr_idx = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_state(input ro_ctrl_state_t s, input int limit, output int cyc);
      cyc = 0;
      while (state_dbg != s && cyc < limit) begin
         tick();
         cyc++;
      end
      if (state_dbg != s) check("wait_state_timeout", 64'(state_dbg), 64'(s));
   endtask

   task automatic wait_rd_valid(input int limit);
      int c;
      c = 0;
      while (!rd_valid && c < limit) begin
         tick();
         c++;
      end
      if (!rd_valid) check("wait_rd_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_sample(input logic [DW-1:0] d);
      logic [63:0] e;
      e = {23'd0, (wr_idx == cur_n - 1), 8'(wr_idx), d};
      exp_wq.push_back(e);
      exp_q.push_back(d);
      wr_idx++;
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit rnd_ready);
      int d0;
      int c;
      d0 = done_cnt;
      c  = 0;
      while (done_cnt == d0 && c < limit) begin
         if (rnd_ready) rd_ready = 1'($urandom_range(0, 1));
         tick();
         c++;
      end
      rd_ready = 1'b1;
      tick();
      tick();
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int d0;
      int a0;
      vectors = 0; miscompares = 0;
      clr_addr_exp = '0; clr_writes = 0; wr_total = 0;
      done_cnt = 0; abort_cnt = 0; wr_idx = 0; cur_n = 0;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_num_samples = '0; cfg_settle_cycles = '0;
      sample_valid = 1'b0; sample_data = '0; rd_ready = 1'b1;
      repeat (3) @(posedge clk_origin);
      #1;
      check("rst_ctrl", 64'({busy, done, aborted, cfg_err, inst_valid, ram_we, ram_re, rd_valid}), 64'd0);
      check("rst_addr", 64'({ram_waddr, ram_raddr}), 64'd0);
      check("rst_wdata", 64'(ram_wdata), 64'd0);
      check("rst_rdata", 64'(rd_data), 64'd0);
      check("rst_count", 64'(sample_count), 64'd0);
      rst = 1'b1;
      tick();

      // 1: clear, settle of 2 with samples ignored, three samples, readout.
      clr_writes = 0; clr_addr_exp = '0;
      do_start(3, 2);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_state(SETTLE, 40, c);
      check("clr_writes", 64'(clr_writes), 64'd16);
      check("inst_valid_settle", 64'(inst_valid), 64'd1);
      sample_valid = 1'b1; sample_data = 32'hDEAD_BEEF;
      c = 0;
      while (state_dbg != MEASURE && c < 20) begin
         tick();
         c++;
      end
      sample_valid = 1'b0;
      check("settle_len", 64'(c), 64'd2);
      send_sample(32'hA);
      tick();
      send_sample(32'hB);
      send_sample(32'hC);
      wait_done(200, 1'b0);
      check("count_t1", 64'(sample_count), 64'd3);
      check("busy_t1", 64'(busy), 64'd0);
      check("q_empty_t1", 64'(exp_q.size() + exp_wq.size()), 64'd0);

      // 2: rejected configurations.
      c = wr_total;
      do_start(0, 0);
      check("cfg_err_n0", 64'({cfg_err, busy}), 64'b10);
      tick();
      check("cfg_err_pulse", 64'(cfg_err), 64'd0);
      do_start(17, 0);
      check("cfg_err_n17", 64'({cfg_err, busy}), 64'b10);
      tick();
      check("busy_n17", 64'(busy), 64'd0);
      check("no_writes_t2", 64'(wr_total - c), 64'd0);

      // 3: consumer stalls for 5 cycles on the first word.
      clr_writes = 0;
      do_start(2, 0);
      wait_state(MEASURE, 40, c);
      check("clr_writes_t3", 64'(clr_writes), 64'd16);
      send_sample($urandom);
      send_sample($urandom);
      rd_ready = 1'b0;
      wait_rd_valid(20);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 64'(rd_valid), 64'd1);
         check("stall_data", 64'(rd_data), 64'(exp_q[0]));
         tick();
      end
      rd_ready = 1'b1;
      tick();
      check("word_done_on_ready", 64'(rd_valid), 64'd0);
      wait_done(100, 1'b0);
      check("count_t3", 64'(sample_count), 64'd2);

      // 4: full depth with two surplus samples, random back-pressure.
      do_start(16, 1);
      wait_state(MEASURE, 40, c);
      for (int i = 0; i < 16; i++) send_sample($urandom);
      sample_valid = 1'b1;
      sample_data  = 32'h1234_5678;
      tick();
      tick();
      sample_valid = 1'b0;
      wait_done(600, 1'b1);
      check("count_t4", 64'(sample_count), 64'd16);
      check("q_empty_t4", 64'(exp_q.size() + exp_wq.size()), 64'd0);

      // 5: abort after two writes, racing a sample; then a one-sample campaign.
      do_start(4, 0);
      wait_state(MEASURE, 40, c);
      send_sample(32'h11);
      send_sample(32'h22);
      a0 = abort_cnt;
      abort = 1'b1; sample_valid = 1'b1; sample_data = 32'h33;
      tick();
      abort = 1'b0; sample_valid = 1'b0;
      check("aborted_pulse", 64'(aborted), 64'd1);
      check("abort_enables", 64'({inst_valid, ram_we, ram_re, rd_valid, busy}), 64'd0);
      check("abort_state", 64'(state_dbg), 64'(IDLE));
      tick();
      check("aborted_once", 64'(abort_cnt - a0), 64'd1);
      check("abort_wq_empty", 64'(exp_wq.size()), 64'd0);
      exp_q.delete();
      do_start(1, 3);
      wait_state(MEASURE, 40, c);
      send_sample(32'h55);
      wait_done(100, 1'b0);
      check("count_t5", 64'(sample_count), 64'd1);

      // 6: reset during readout.
      do_start(2, 0);
      wait_state(MEASURE, 40, c);
      send_sample($urandom);
      send_sample($urandom);
      rd_ready = 1'b0;
      wait_rd_valid(20);
      d0 = done_cnt; a0 = abort_cnt;
      #2 rst = 1'b0;
      #1;
      check("rst_mid_ctrl", 64'({busy, done, aborted, cfg_err, inst_valid, ram_we, ram_re, rd_valid}), 64'd0);
      check("rst_mid_data", 64'({rd_data, ram_wdata}), 64'd0);
      check("rst_mid_addr", 64'({sample_count, ram_waddr, ram_raddr}), 64'd0);
      exp_q.delete();
      exp_wq.delete();
      tick();
      rst = 1'b1;
      rd_ready = 1'b1;
      repeat (5) tick();
      check("rst_no_pulses", 64'({16'(done_cnt - d0), 16'(abort_cnt - a0)}), 64'd0);
      check("rst_idle", 64'({busy, state_dbg}), 64'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
